// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request/grant/response
// transaction in flight at most, and holds one fetched instruction for IF/ID.
//
// state  | meaning
// S_IDLE | first cycle after reset release, no request yet
// S_REQ  | request driven at fetch_pc, waiting for grant
// S_WAIT | granted, waiting for the response
// S_HOLD | instruction presented to IF/ID, waiting for it to be taken
// S_DROP | granted on a squashed path, swallowing its response
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_branch_flag_i,
  input  logic [31:0] ex_branch_addr_i,
  input  logic [2:0]  stalled,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stallreq_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  // Only the IF/ID hold bit matters here; the low target bits are forced to
  // zero for word alignment.
  logic unused_inputs;
  assign unused_inputs = ^{stalled[2:1], ex_branch_addr_i[1:0]};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= 32'h0;
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state and datapath update; a redirect squashes the presented
  // instruction and decides whether an in-flight response must be dropped.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    if (ex_branch_flag_i) begin
      fetch_pc_d = {ex_branch_addr_i[31:2], 2'b00};
      valid_d    = 1'b0;
      inst_d     = NOP_INST;
      pc_d       = 32'h0;
      case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = ibus_gnt_i ? S_DROP : S_REQ;
        S_WAIT:  state_d = ibus_rvalid_i ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        S_DROP:  state_d = ibus_rvalid_i ? S_REQ : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (ibus_gnt_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (ibus_rvalid_i) begin
            inst_d     = ibus_rdata_i;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stalled[0]) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            pc_d    = 32'h0;
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          if (ibus_rvalid_i) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ibus_req_o   = (state_q == S_REQ);
  assign ibus_addr_o  = fetch_pc_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign stallreq_o   = ~valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a transaction-level reference model
// compared every cycle, plus literal expectations at key points.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_addr = 32'h0;
  logic [2:0]  stalled = 3'b000;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid;
  logic        stallreq;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  if_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .ex_branch_flag_i (br),
    .ex_branch_addr_i (br_addr),
    .stalled          (stalled),
    .ibus_req_o       (req),
    .ibus_addr_o      (addr),
    .ibus_gnt_i       (gnt),
    .ibus_rvalid_i    (rvalid),
    .ibus_rdata_i     (rdata),
    .pc_o             (pc),
    .inst_o           (inst),
    .inst_valid_o     (valid),
    .stallreq_o       (stallreq)
  );

  always #5 clk = ~clk;

  // Reference model in transaction terms: a boot cycle, one outstanding
  // transaction (possibly squashed), and a single presented-instruction slot.
  bit          m_boot = 1'b1;
  bit          m_out = 1'b0;
  bit          m_sq = 1'b0;
  bit          m_have = 1'b0;
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_inst = NOP;
  bit          n_boot, n_out, n_sq, n_have;
  logic [31:0] n_fpc, n_pc, n_inst;

  function automatic bit m_req();
    return !m_boot && !m_out && !m_have;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_boot = 1'b1; m_out = 1'b0; m_sq = 1'b0; m_have = 1'b0;
      m_fpc = 32'h0; m_pc = 32'h0; m_inst = NOP;
    end else begin
      n_boot = 1'b0; n_out = m_out; n_sq = m_sq; n_have = m_have;
      n_fpc = m_fpc; n_pc = m_pc; n_inst = m_inst;
      if (br) begin
        n_fpc = {br_addr[31:2], 2'b00};
        n_have = 1'b0; n_pc = 32'h0; n_inst = NOP;
      end
      if (m_req() && gnt) begin
        n_out = 1'b1;
        n_sq = br;
      end
      if (m_out && rvalid) begin
        n_out = 1'b0;
        n_sq = 1'b0;
        if (!m_sq && !br) begin
          n_have = 1'b1; n_pc = m_fpc; n_inst = rdata; n_fpc = m_fpc + 32'd4;
        end
      end else if (m_out && br) begin
        n_sq = 1'b1;
      end
      if (m_have && !stalled[0] && !br) begin
        n_have = 1'b0; n_pc = 32'h0; n_inst = NOP;
      end
      m_boot = n_boot; m_out = n_out; m_sq = n_sq; m_have = n_have;
      m_fpc = n_fpc; m_pc = n_pc; m_inst = n_inst;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("model_req", {31'h0, req}, {31'h0, (rst && m_req())});
      if (req) chk("model_addr", addr, m_fpc);
      chk("model_pc", pc, m_pc);
      chk("model_inst", inst, m_inst);
      chk("model_valid", {31'h0, valid}, {31'h0, m_have});
      chk("model_stallreq", {31'h0, stallreq}, {31'h0, !m_have});
    end
  end

  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic st, input logic b, input logic [31:0] ba);
    gnt = g; rvalid = rv; rdata = rd; stalled = {2'b00, st}; br = b; br_addr = ba;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_stallreq", {31'h0, stallreq}, 32'h1);
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_vals();
    started = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("first_req", {31'h0, req}, 32'h1);
    chk("first_addr", addr, 32'h0);

    // Fast bus: grant now, response next cycle.
    step(1, 0, 0, 0, 0, 0);
    chk("wait_noreq", {31'h0, req}, 32'h0);
    step(0, 1, 32'h0050_0093, 0, 0, 0);
    chk("t1_valid", {31'h0, valid}, 32'h1);
    chk("t1_pc", pc, 32'h0);
    chk("t1_inst", inst, 32'h0050_0093);
    chk("t1_stallreq", {31'h0, stallreq}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_next_addr", addr, 32'h4);
    chk("t1_next_req", {31'h0, req}, 32'h1);
    chk("t1_cleared_inst", inst, NOP);

    // Slow bus: grant withheld three cycles.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("slow_req", {31'h0, req}, 32'h1);
      chk("slow_addr", addr, 32'h4);
      chk("slow_stallreq", {31'h0, stallreq}, 32'h1);
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0010_8113, 1, 0, 0);
    chk("t2_pc", pc, 32'h4);

    // Held by IF/ID stall for four cycles; stray rvalid is ignored.
    for (int i = 0; i < 4; i++) begin
      step(0, (i == 1), 32'h1234_5678, 1, 0, 0);
      chk("hold_pc", pc, 32'h4);
      chk("hold_inst", inst, 32'h0010_8113);
      chk("hold_noreq", {31'h0, req}, 32'h0);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("release_valid", {31'h0, valid}, 32'h0);
    chk("release_addr", addr, 32'h8);

    // Redirect while waiting; late response is discarded.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0000_0102);
    step(0, 0, 0, 0, 0, 0);
    chk("drop_noreq", {31'h0, req}, 32'h0);
    step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("drop_valid", {31'h0, valid}, 32'h0);
    chk("drop_addr", addr, 32'h0000_0100);
    chk("drop_req", {31'h0, req}, 32'h1);

    // Redirect coincident with grant: one response swallowed.
    step(1, 0, 0, 0, 1, 32'h0000_0200);
    chk("gntbr_noreq", {31'h0, req}, 32'h0);
    step(0, 1, 32'hCAFE_0001, 0, 0, 0);
    chk("gntbr_addr", addr, 32'h0000_0200);
    chk("gntbr_valid", {31'h0, valid}, 32'h0);

    // Redirect coincident with response: straight back to request.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hCAFE_0002, 0, 1, 32'h0000_0300);
    chk("rvbr_req", {31'h0, req}, 32'h1);
    chk("rvbr_addr", addr, 32'h0000_0300);
    chk("rvbr_valid", {31'h0, valid}, 32'h0);

    // Redirect while requesting without grant; stray rvalid in request ignored.
    step(0, 1, 32'h1111_1111, 0, 1, 32'h0000_0407);
    chk("reqbr_addr", addr, 32'h0000_0404);
    chk("reqbr_req", {31'h0, req}, 32'h1);

    // Redirect while holding loses the held instruction.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0404, 1, 0, 0);
    chk("holdbr_pre_pc", pc, 32'h0000_0404);
    step(0, 0, 0, 1, 1, 32'h0000_0500);
    chk("holdbr_valid", {31'h0, valid}, 32'h0);
    chk("holdbr_addr", addr, 32'h0000_0500);

    // PC wrap at the top of the address space.
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_addr", addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0073, 0, 0, 0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_next_addr", addr, 32'h0);

    // Reset in the middle of a transaction.
    step(1, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    gnt = 1'b0;
    @(posedge clk); #1;
    chk("rerst_req", {31'h0, req}, 32'h1);
    chk("rerst_addr", addr, 32'h0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0020_0113, 0, 0, 0);
    chk("rerst_inst", inst, 32'h0020_0113);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the bittyCore pipeline. Sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and runs a single-outstanding request/grant/response handshake on the instruction bus.
- Presents one fetched instruction (pc_o/inst_o) to IF/ID and raises stallreq_o to ctrl while none is available.
- Redirects on EX branch and discards any in-flight response belonging to the squashed path.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, value driven on inst_o when no valid instruction (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (RstEnable = 0)
ex_branch_flag_i  input  1  EX redirect request, BranchEnable = 1
ex_branch_addr_i  input  32  redirect target
stalled  input  3  ctrl stall vector; stalled[0] = IF/ID hold (NoStop = 0)
ibus_req_o  output  1  instruction bus request
ibus_addr_o  output  32  request address, word aligned
ibus_gnt_i  input  1  bus accepted request this cycle
ibus_rvalid_i  input  1  read data valid
ibus_rdata_i  input  32  read data
pc_o  output  32  PC of presented instruction
inst_o  output  32  presented instruction
inst_valid_o  output  1  pc_o/inst_o hold a real fetched instruction
stallreq_o  output  1  combinational ~inst_valid_o, to ctrl

Behaviour:
- Reset (rst=0, async): state=S_IDLE, fetch_pc=RESET_PC, ibus_req_o=0, ibus_addr_o=RESET_PC, pc_o=0, inst_o=NOP_INST, inst_valid_o=0, stallreq_o=1.
- Reset deasserted mid-transaction: the bus side is also reset; no response from before reset is expected.
- States:
  - S_IDLE: one cycle after reset release, then S_REQ.
  - S_REQ: ibus_req_o=1, ibus_addr_o=fetch_pc. Addr held stable until gnt, except on redirect. On gnt -> S_WAIT.
  - S_WAIT: req=0. On rvalid: capture rdata to inst_o and fetch_pc to pc_o, set inst_valid_o=1, fetch_pc+=4, -> S_HOLD.
  - S_HOLD: outputs held. When stalled[0]==NoStop at a clock edge, IF/ID captures; that edge clears inst_valid_o, sets inst_o=NOP_INST and pc_o=0, -> S_REQ.
  - S_DROP: req=0. Awaits one rvalid, discards its data, -> S_REQ.
- stalled[0] is ignored outside S_HOLD.
- Redirect (ex_branch_flag_i=1) overrides everything except reset, at that edge:
  - fetch_pc = {ex_branch_addr_i[31:2],2'b00}.
  - inst_valid_o=0, inst_o=NOP_INST, pc_o=0.
  - Next state by current state and bus inputs:
    - S_REQ, no gnt -> S_REQ; the new address appears next cycle. Slaves sample addr only with gnt.
    - S_REQ with gnt -> S_DROP.
    - S_WAIT, no rvalid -> S_DROP.
    - S_WAIT with rvalid -> S_REQ; data discarded.
    - S_HOLD -> S_REQ; the held instruction is lost.
    - S_DROP, no rvalid -> S_DROP.
    - S_DROP with rvalid -> S_REQ.
- Exactly one outstanding bus transaction. No new req while in S_WAIT or S_DROP.
- Latency: with gnt in the S_REQ cycle and rvalid one cycle later, inst_valid_o rises 2 cycles after req. Peak rate is 1 instruction per 3 cycles.
- PC arithmetic: 32-bit modulo; 0xFFFF_FFFC + 4 = 0x0000_0000.
- ibus_rvalid_i in S_REQ/S_HOLD/S_IDLE is a bus protocol error: ignored, no state change.

Test Plan:
- Reset release, gnt same cycle, rvalid 1 cycle later, rdata=0x00500093, stalled=0 -> req at 0x0 in cycle 2; inst_valid_o=1, pc_o=0, inst_o=0x00500093; next req addr 0x4.
- Slow bus: gnt withheld 3 cycles -> ibus_addr_o stable at 0x4 and req=1 throughout; stallreq_o=1 until rvalid.
- Valid instruction with stalled[0]=1 for 4 cycles -> pc_o/inst_o unchanged, no new req; stalled[0]=0 -> valid clears and req for next PC the following cycle.
- Branch to 0x0000_0102 asserted in S_WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data discarded, inst_valid_o stays 0, next req addr 0x0000_0100.
- Branch coincident with gnt in S_REQ -> S_DROP, one response swallowed, then req at branch target; and branch with rvalid in same cycle -> immediate S_REQ at target.
- fetch_pc=0xFFFF_FFFC fetched and consumed -> next req addr 0x0000_0000.
